rr_arbiter2x64: RTL and testbench
=================================

// Module: rr_arbiter2x64
// PURPOSE
//  Round-robin arbiter that shares one 64-bit downstream port between two requesters.
//  Sequences the 2:1 x64 data-select mux and a one-entry registered output stage.
//  Multi-beat bursts hold the grant until their last beat.
//  Sits in front of shared in-order resources, e.g. the writeback or memory port.
// PARAMETERS
//  DATA_W   64  width of each data beat
//  LOCK_EN  1   1: hold grant until req_last beat; 0: every beat is treated as last
// PORTS
//  clk          in   1         system clock; all state updates on posedge
//  reset        in   1         synchronous, active-high reset
//  req_valid    in   2         per-requester beat valid
//  req_data     in   2xDATA_W  per-requester beat data, packed [1:0][DATA_W-1:0]
//  req_last     in   2         per-requester final beat of burst
//  req_ready    out  2         beat accepted this cycle (combinational)
//  out_valid    out  1         registered output beat valid
//  out_data     out  DATA_W    registered output data
//  out_last     out  1         registered last flag
//  out_src      out  1         requester index that supplied out_data
//  out_ready    in   1         downstream accepts out beat
//  busy         out  1         burst lock held (state != IDLE)
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_last=0, out_src=0, state=IDLE, prio=0, busy=0.
//   req_ready=0 while reset=1.
//  Load enable: ld = !out_valid | out_ready. Output register loads only when ld=1.
//  Grant (combinational):
//   IDLE: if exactly one req_valid, that requester wins; if both, requester==prio wins.
//   LOCKi: grant=i only, even if req_valid[i]=0; the other requester stalls.
//  Transfers:
//   req_ready[g]=ld & req_valid[g] for grant g; the other req_ready bit is 0.
//   xfer = req_ready[g].
//  On xfer, next cycle: out_valid=1, out_data=req_data[g], out_last=req_last[g], out_src=g.
//   Latency is 1 cycle, throughput 1 beat/cycle.
//  On ld & !xfer: out_valid<=0 (bubble). On !ld: output register holds unchanged.
//  FSM IDLE/LOCK0/LOCK1:
//   xfer from g with last=0 (and LOCK_EN=1) -> LOCKg.
//   xfer with last=1 -> IDLE, prio<=~g.
//   No xfer -> state holds.
//  Single-beat (last=1) transfer from IDLE: stays IDLE, prio still toggles to ~g.
//  Lock bubble: in LOCKi with req_valid[i]=0, no transfer; lock is held, never broken.
//  Backpressure: out_ready=0 with out_valid=1 -> req_ready=0 and all state frozen.
//  Reset mid-burst: lock dropped, prio=0, staged beat discarded (out_valid=0 next cycle).
//  busy is registered: 1 in LOCK0/LOCK1.
//  No X propagation: out_data holds its last value when out_valid=0.
// STRUCTURE
//  Shared package arb_pkg:
//   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t; DATA_W default constant.
//  Sub-module rr_pick2:
//   Pure combinational; inputs valid[1:0], prio, state; outputs grant, grant_vld.
//  Datapath: 2:1 x64 mux selected by grant feeding the output register.
// TESTING
//  1. Reset, then req_valid=01, data0=64'hA5A5_0000_0000_0001, last=1, out_ready=1
//     -> req_ready=01; next cycle out_valid=1, out_data=A5A5..01, out_src=0.
//  2. Both valid, single beats, prio=0, out_ready=1 for 4 cycles
//     -> grants alternate 0,1,0,1; out_src alternates 0,1,0,1.
//  3. Req0 3-beat burst (last on beat 3) while req1 continuously valid
//     -> 3 consecutive out_src=0 beats, busy=1 after beat 1, then req1 granted.
//  4. out_ready=0 for 5 cycles with out_valid=1 and both requesting
//     -> out_data stable, req_ready=00, state and prio unchanged.
//  5. LOCK1 with req_valid[1] dropped for 2 cycles and req_valid[0]=1
//     -> req_ready=00, out_valid=0 bubbles; burst resumes on req1 return.
//  6. reset asserted mid-burst in LOCK0
//     -> next cycle out_valid=0, busy=0; both valid afterwards -> req0 granted (prio=0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package arb_pkg;

  localparam int unsigned ARB_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational grant selection: round-robin priority in IDLE, fixed owner while locked.
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  input  arb_state_t state,
  output logic       grant,
  output logic       grant_vld
);

  always_comb begin
    grant     = prio;
    grant_vld = 1'b0;
    case (state)
      LOCK0: begin
        grant     = 1'b0;
        grant_vld = valid[0];
      end
      LOCK1: begin
        grant     = 1'b1;
        grant_vld = valid[1];
      end
      default: begin
        if (valid == 2'b01) begin
          grant = 1'b0;
        end else if (valid == 2'b10) begin
          grant = 1'b1;
        end
        grant_vld = |valid;
      end
    endcase
  end

endmodule

// File: rtl/rr_arbiter2x64.sv
// Round-robin 2:1 arbiter with burst locking and a one-entry registered output stage.
module rr_arbiter2x64
  import arb_pkg::*;
#(
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter bit          LOCK_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  input  logic [1:0][DATA_W-1:0] req_data,
  input  logic [1:0]             req_last,
  output logic [1:0]             req_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic                   out_src,
  input  logic                   out_ready,
  output logic                   busy
);

  arb_state_t state_q, state_d;
  logic       prio_q, prio_d;
  logic       grant, grant_vld;
  logic       ld, xfer, beat_last;

  rr_pick2 u_pick (
    .valid     (req_valid),
    .prio      (prio_q),
    .state     (state_q),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // Output stage can take a beat when empty or draining this cycle.
  assign ld        = !out_valid || out_ready;
  assign xfer      = ld && grant_vld && !reset;
  assign req_ready = xfer ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign beat_last = !LOCK_EN || req_last[grant];

  // Next-state and round-robin priority update.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (xfer) begin
      if (beat_last) begin
        state_d = IDLE;
        prio_d  = ~grant;
      end else begin
        state_d = grant ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Registered output beat; data is held across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (ld) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= req_data[grant];
        out_last  <= beat_last;
        out_src   <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter2x64.sv
// Directed self-checking bench for rr_arbiter2x64.
module tb_rr_arbiter2x64;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0][63:0] req_data;
  logic [1:0]       req_last;
  logic [1:0]       req_ready;
  logic             out_valid;
  logic [63:0]      out_data;
  logic             out_last;
  logic             out_src;
  logic             out_ready;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter2x64 dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 2'b01; req_last = 2'b11; out_ready = 1'b1;
    req_data[0] = 64'h1111; req_data[1] = 64'h2222;
    reset = 1'b1;
    step(); step();
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got %b exp 00", req_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    n_checks++; if (busy !== 1'b0 || out_src !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL rst_flags got busy=%b src=%b last=%b exp 0", busy, out_src, out_last); end
    reset = 1'b0;
    req_data[0] = 64'hA5A5_0000_0000_0001;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL t1_ready got %b exp 01", req_ready); end
    step();
    req_valid = 2'b00;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t1_out_valid got %b exp 1", out_valid); end
    n_checks++; if (out_data !== 64'hA5A5_0000_0000_0001) begin n_fail++; $display("FAIL t1_out_data got %h exp a5a5000000000001", out_data); end
    n_checks++; if (out_src !== 1'b0 || out_last !== 1'b1) begin n_fail++; $display("FAIL t1_src_last got src=%b last=%b exp src=0 last=1", out_src, out_last); end
  endtask

  task automatic test_alternate();
    req_valid = 2'b00; req_last = 2'b11; out_ready = 1'b1;
    do_reset();
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic exp_g;
      exp_g = k[0];
      req_data[0] = 64'h100 + 64'(k);
      req_data[1] = 64'h200 + 64'(k);
      #1;
      n_checks++; if (req_ready !== (exp_g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_ready[%0d] got %b exp %b", k, req_ready, (exp_g ? 2'b10 : 2'b01)); end
      step();
      n_checks++; if (out_src !== exp_g || out_valid !== 1'b1) begin n_fail++; $display("FAIL alt_src[%0d] got src=%b vld=%b exp src=%b vld=1", k, out_src, out_valid, exp_g); end
      n_checks++; if (out_data !== (exp_g ? 64'h200 : 64'h100) + 64'(k)) begin n_fail++; $display("FAIL alt_data[%0d] got %h", k, out_data); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_burst_lock();
    req_valid = 2'b00; req_last = 2'b11; out_ready = 1'b1;
    do_reset();
    req_valid = 2'b11; req_data[1] = 64'hBBBB;
    for (int b = 0; b < 3; b++) begin
      req_last[0] = (b == 2);
      req_data[0] = 64'hC000 + 64'(b);
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL burst_ready[%0d] got %b exp 01", b, req_ready); end
      step();
      n_checks++; if (out_src !== 1'b0 || out_data !== 64'hC000 + 64'(b)) begin n_fail++; $display("FAIL burst_beat[%0d] got src=%b data=%h exp src=0 data=%h", b, out_src, out_data, 64'hC000 + 64'(b)); end
      n_checks++; if (busy !== (b != 2) || out_last !== (b == 2)) begin n_fail++; $display("FAIL burst_busy[%0d] got busy=%b last=%b exp busy=%b last=%b", b, busy, out_last, (b != 2), (b == 2)); end
    end
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL burst_next_ready got %b exp 10", req_ready); end
    step();
    n_checks++; if (out_src !== 1'b1 || out_data !== 64'hBBBB) begin n_fail++; $display("FAIL burst_next_src got src=%b data=%h exp src=1 data=bbbb", out_src, out_data); end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    req_valid = 2'b00; req_last = 2'b11; out_ready = 1'b1;
    do_reset();
    req_valid = 2'b11; req_last = 2'b10;
    req_data[0] = 64'hDEAD_0000; req_data[1] = 64'hBEEF_0000;
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_data[0] = 64'hDEAD_0010 + 64'(c);
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 00", c, req_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_data !== 64'hDEAD_0000 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] got vld=%b data=%h busy=%b exp vld=1 data=dead0000 busy=1", c, out_valid, out_data, busy); end
    end
    out_ready = 1'b1; req_last = 2'b11; req_data[0] = 64'hDEAD_0001;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_lock_kept got %b exp 01", req_ready); end
    step();
    n_checks++; if (out_data !== 64'hDEAD_0001 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release got data=%h busy=%b exp data=dead0001 busy=0", out_data, busy); end
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_prio got %b exp 10", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_lock_bubble();
    req_valid = 2'b00; req_last = 2'b11; out_ready = 1'b1;
    do_reset();
    req_valid = 2'b10; req_last = 2'b00;
    req_data[0] = 64'h0A0A; req_data[1] = 64'h1B00;
    step();
    n_checks++; if (busy !== 1'b1 || out_src !== 1'b1) begin n_fail++; $display("FAIL bub_lock got busy=%b src=%b exp busy=1 src=1", busy, out_src); end
    req_valid = 2'b01;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bub_ready[%0d] got %b exp 00", c, req_ready); end
      step();
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || out_data !== 64'h1B00) begin n_fail++; $display("FAIL bub_out[%0d] got vld=%b busy=%b data=%h exp vld=0 busy=1 data=1b00", c, out_valid, busy, out_data); end
    end
    req_valid = 2'b11; req_last = 2'b10; req_data[1] = 64'h1B01;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bub_resume_ready got %b exp 10", req_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_src !== 1'b1 || out_last !== 1'b1 || out_data !== 64'h1B01 || busy !== 1'b0) begin n_fail++; $display("FAIL bub_resume got vld=%b src=%b last=%b data=%h busy=%b", out_valid, out_src, out_last, out_data, busy); end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_burst();
    req_valid = 2'b00; req_last = 2'b11; out_ready = 1'b1;
    do_reset();
    req_valid = 2'b11; req_last = 2'b10;
    req_data[0] = 64'hE000; req_data[1] = 64'hF000;
    step();
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_lock got busy=%b vld=%b exp 1 1", busy, out_valid); end
    reset = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 00", req_ready); end
    step();
    reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out got vld=%b busy=%b exp 0 0", out_valid, busy); end
    req_last = 2'b11; req_data[0] = 64'hE001;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_after_ready got %b exp 01", req_ready); end
    step();
    n_checks++; if (out_src !== 1'b0 || out_data !== 64'hE001) begin n_fail++; $display("FAIL mid_after_src got src=%b data=%h exp 0 e001", out_src, out_data); end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_burst_lock();
    test_backpressure();
    test_lock_bubble();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
